// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared types and constants for the PLL lock supervisor.
//  - state_t      : supervisor FSM states (3-bit encoding)
//  - DEF_*        : default cycle counts for a 27 MHz reference clock
//  - sat_inc()    : saturating increment used by the cycle and event counters
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int DEF_PLL_RST_CYCLES      = 32;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 27000;  // 1 ms at 27 MHz
  localparam int DEF_MAX_RETRIES         = 7;
  localparam int DEF_CNT_W               = 16;

  // v+1, but never past max_v
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level.
//  i_clk  : destination clock
//  i_rst  : asynchronous active-high reset, both flops cleared to 0
//  i_d    : asynchronous input
//  o_q    : synchronised output, 2 clk latency
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences the rPLL bring-up from the 27 MHz reference.
// Holds the PLL in reset, waits for LOCK, qualifies it as stable, then releases
// the downstream system reset. Lock loss or lock timeout re-runs the sequence;
// too many failed attempts park the block in FAIL until restart or reset.
//  i_clk           : 27 MHz reference clock
//  i_reset         : asynchronous active-high reset
//  i_pll_lock      : PLL LOCK pin (asynchronous, synchronised here)
//  i_restart       : one-cycle request to re-run the full sequence
//  o_pll_reset     : PLL RESET pin, high holds the PLL in reset
//  o_sys_reset     : active-high reset for downstream logic, low only in RUN
//  o_ready         : high only in RUN
//  o_failed        : high only in FAIL
//  o_retry_cnt     : failed attempts in the current acquisition (sat. 15)
//  o_lock_loss_cnt : lock drops seen in RUN since reset (sat. 255)
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pll_lock,
  input  logic       i_restart,
  output logic       o_pll_reset,
  output logic       o_sys_reset,
  output logic       o_ready,
  output logic       o_failed,
  output logic [3:0] o_retry_cnt,
  output logic [7:0] o_lock_loss_cnt
);

  // CNT_W must stay below 32 for this all-ones constant
  localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_retry_cnt;
  logic [7:0]         r_lock_loss_cnt;
  logic               r_pll_reset;
  logic               r_sys_reset;
  logic               r_ready;
  logic               r_failed;

  logic               w_lock_s;
  state_t             w_nxt;
  logic               w_timeout;
  logic               w_lose;
  logic               w_enter_run;

  sync_2ff u_lock_sync (
    .i_clk (i_clk),
    .i_rst (i_reset),
    .i_d   (i_pll_lock),
    .o_q   (w_lock_s)
  );

  // Next-state decode. restart overrides every other transition; a lock drop
  // in RUN on the same cycle is still counted via w_lose.
  always_comb begin
    w_nxt       = r_state;
    w_timeout   = 1'b0;
    w_lose      = (r_state == RUN) && !w_lock_s;
    if (i_restart) begin
      w_nxt = PLL_RST;
    end else begin
      case (r_state)
        PLL_RST:
          if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) w_nxt = WAIT_LOCK;
        WAIT_LOCK:
          if (w_lock_s) begin
            w_nxt = STABLE;
          end else if (r_cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            w_timeout = 1'b1;
            w_nxt     = (r_retry_cnt == 4'(MAX_RETRIES)) ? FAIL : PLL_RST;
          end
        // a lock dip restarts the timeout window without charging a retry
        STABLE:
          if (!w_lock_s)                                     w_nxt = WAIT_LOCK;
          else if (r_cnt == CNT_W'(LOCK_STABLE_CYCLES - 1))  w_nxt = RUN;
        RUN:
          if (!w_lock_s) w_nxt = PLL_RST;
        FAIL:    w_nxt = FAIL;
        default: w_nxt = PLL_RST;
      endcase
    end
    w_enter_run = (w_nxt == RUN) && (r_state != RUN);
  end

  // Outputs are decoded from the next state so they switch on the same edge
  // as r_state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= PLL_RST;
      r_cnt           <= '0;
      r_retry_cnt     <= '0;
      r_lock_loss_cnt <= '0;
      r_pll_reset     <= 1'b1;
      r_sys_reset     <= 1'b1;
      r_ready         <= 1'b0;
      r_failed        <= 1'b0;
    end else begin
      r_state <= w_nxt;

      // restart re-enters PLL_RST even from PLL_RST, so give it a full hold
      if (i_restart || (w_nxt != r_state)) r_cnt <= '0;
      else                                 r_cnt <= CNT_W'(sat_inc(32'(r_cnt), CNT_MAX));

      if (i_restart || w_enter_run) r_retry_cnt <= '0;
      else if (w_timeout)           r_retry_cnt <= 4'(sat_inc(32'(r_retry_cnt), 32'd15));

      if (w_lose) r_lock_loss_cnt <= 8'(sat_inc(32'(r_lock_loss_cnt), 32'd255));

      r_pll_reset <= (w_nxt == PLL_RST) || (w_nxt == FAIL);
      r_sys_reset <= (w_nxt != RUN);
      r_ready     <= (w_nxt == RUN);
      r_failed    <= (w_nxt == FAIL);
    end
  end

  assign o_pll_reset     = r_pll_reset;
  assign o_sys_reset     = r_sys_reset;
  assign o_ready         = r_ready;
  assign o_failed        = r_failed;
  assign o_retry_cnt     = r_retry_cnt;
  assign o_lock_loss_cnt = r_lock_loss_cnt;

endmodule
